// File: rtl/tone_bank_generator.sv
// tone_bank_generator: CHANNELS independent square-wave tone channels with glitch-free period/duty reload.
// Optional TONE_BANK_SYNC_EN adds a `sync` input that realigns all enabled, loaded channels.
module tone_bank_generator #(
    parameter int CHANNELS      = 4,
    parameter int CNT_W         = 32,
    parameter int DUTY_W        = 8,
    parameter int CLK_PERIOD_NS = 20
) (
    input  logic                            clk,
    input  logic                            rst,
`ifdef TONE_BANK_SYNC_EN
    input  logic                            sync,
`endif
    input  logic [CHANNELS-1:0]             en,
    input  logic [CHANNELS*CNT_W-1:0]       period,
    input  logic [CHANNELS*DUTY_W-1:0]      duty,
    output logic [CHANNELS-1:0]             wave,
    output logic [CHANNELS-1:0]             tick,
    output logic [$clog2(CHANNELS+1)-1:0]   mix
);
    localparam int MW = $clog2(CHANNELS+1);
    localparam logic [CNT_W:0] STEP = (CNT_W+1)'(CLK_PERIOD_NS);

    logic do_sync;
`ifdef TONE_BANK_SYNC_EN
    assign do_sync = sync;
`else
    assign do_sync = 1'b0;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CNT_W-1:0] acc, p_sh, hi_sh, p_in, hi_new;
        logic [DUTY_W-1:0] d_in;
        logic [CNT_W+DUTY_W-1:0] prod;
        logic [CNT_W:0] nxt;
        logic loaded, valid, wrap, w, t;
        assign p_in   = period[c*CNT_W +: CNT_W];
        assign d_in   = duty[c*DUTY_W +: DUTY_W];
        assign prod   = (CNT_W+DUTY_W)'(p_in) * (CNT_W+DUTY_W)'(d_in);
        assign hi_new = CNT_W'(prod >> DUTY_W);
        assign nxt    = {1'b0, acc} + STEP;
        assign wrap   = nxt >= {1'b0, p_sh};
        assign valid  = {1'b0, p_sh} >= STEP;
        // Shadow regs reload only on first enable, wrap, sync or while invalid, so a running period never glitches.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc    <= '0;
                p_sh   <= '0;
                hi_sh  <= '0;
                loaded <= 1'b0;
                w      <= 1'b0;
                t      <= 1'b0;
            end else if (!en[c]) begin
                acc    <= '0;
                loaded <= 1'b0;
                w      <= 1'b0;
                t      <= 1'b0;
            end else if (!loaded || do_sync || !valid || wrap) begin
                p_sh   <= p_in;
                hi_sh  <= hi_new;
                acc    <= '0;
                loaded <= 1'b1;
                w      <= loaded && !do_sync && valid && (acc < hi_sh);
                t      <= loaded && !do_sync && valid;
            end else begin
                acc <= nxt[CNT_W-1:0];
                w   <= acc < hi_sh;
                t   <= 1'b0;
            end
        end
        assign wave[c] = w;
        assign tick[c] = t;
    end

    logic [MW-1:0] pc;
    always_comb begin
        pc = '0;
        for (int i = 0; i < CHANNELS; i++) pc = pc + MW'(wave[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mix <= '0;
        else     mix <= pc;
    end
endmodule
